// File: rtl/gray_counter_codec.sv
// Registered up/down Gray counter with parallel load, plus an independent Gray-to-binary decode channel.
// Optional Gray sequence checker on the decode channel is enabled by defining GRAY_CHK_EN.
module gray_counter_codec #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] G,
    output logic             tc,
    input  logic [WIDTH-1:0] g_in,
    input  logic             g_in_vld,
    output logic [WIDTH-1:0] b_out,
    output logic             b_out_vld,
    output logic             chk_err
);

    localparam logic [WIDTH-1:0] RST_B = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_G = RST_B ^ (RST_B >> 1);

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] bout_q, bout_d;
    logic [WIDTH-1:0] dec;
    logic             vld_q;

    // G is derived from the next binary value so both registers change on the same edge.
    always_comb begin
        b_d = b_q;
        if (load) begin
            b_d = load_bin;
        end else if (en) begin
            if (up) begin
                b_d = b_q + WIDTH'(1);
            end else begin
                b_d = b_q - WIDTH'(1);
            end
        end
        g_d = b_d ^ (b_d >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q <= RST_B;
            g_q <= RST_G;
        end else begin
            b_q <= b_d;
            g_q <= g_d;
        end
    end

    assign B  = b_q;
    assign G  = g_q;
    assign tc = up ? (&b_q) : ~(|b_q);

    // MSB passes through; each lower bit is the XOR of g_in and the decoded bit above it.
    always_comb begin
        dec = '0;
        dec[WIDTH-1] = g_in[WIDTH-1];
        for (int unsigned i = 2; i <= WIDTH; i++) begin
            dec[WIDTH-i] = dec[WIDTH-i+1] ^ g_in[WIDTH-i];
        end
        bout_d = g_in_vld ? dec : bout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            bout_q <= bout_d;
            vld_q  <= g_in_vld;
        end
    end

    assign b_out     = bout_q;
    assign b_out_vld = vld_q;

`ifdef GRAY_CHK_EN
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] diff;
    logic             multi;
    logic             armed_q;
    logic             err_q;

    // diff & (diff - 1) is non-zero exactly when more than one bit changed.
    always_comb begin
        diff  = g_in ^ ref_q;
        multi = (diff & (diff - WIDTH'(1))) != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q   <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= g_in_vld && armed_q && multi;
            if (g_in_vld) begin
                ref_q   <= g_in;
                armed_q <= 1'b1;
            end
        end
    end

    assign chk_err = err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_codec.sv
// Scoreboard bench for gray_counter_codec (WIDTH=4); decode expectations are queued at drive time.
module tb_gray_counter_codec;

    logic       clk = 1'b0;
    logic       rst, rst5;
    logic       en, up, load, g_in_vld;
    logic [3:0] load_bin, g_in;
    logic [3:0] B, G, b_out;
    logic       tc, b_out_vld, chk_err;
    logic [3:0] B5, G5, b_out5;
    logic       tc5, b_out_vld5, chk_err5;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       vld;
        logic [3:0] b;
        logic       err;
    } dec_exp_t;

    dec_exp_t   sb[$];
    logic [3:0] mb, mbo, mref;
    logic       marmed;
    logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    always #5 clk = ~clk;

    gray_counter_codec #(.WIDTH(4), .RST_VAL(0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
        .B(B), .G(G), .tc(tc), .g_in(g_in), .g_in_vld(g_in_vld),
        .b_out(b_out), .b_out_vld(b_out_vld), .chk_err(chk_err)
    );

    gray_counter_codec #(.WIDTH(4), .RST_VAL(5)) u_dut5 (
        .clk(clk), .rst(rst5), .en(en), .up(up), .load(load), .load_bin(load_bin),
        .B(B5), .G(G5), .tc(tc5), .g_in(g_in), .g_in_vld(g_in_vld),
        .b_out(b_out5), .b_out_vld(b_out_vld5), .chk_err(chk_err5)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] r;
        r[3] = g[3];
        r[2] = g[3] ^ g[2];
        r[1] = g[3] ^ g[2] ^ g[1];
        r[0] = g[3] ^ g[2] ^ g[1] ^ g[0];
        return r;
    endfunction

    task automatic model_reset();
        mb     = 4'd0;
        mbo    = 4'd0;
        mref   = 4'd0;
        marmed = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of decode stimulus, advance one clock, then check counter and scoreboard.
    task automatic tick(input logic v, input logic [3:0] g);
        dec_exp_t   e;
        logic       ld, ce, cu;
        logic [3:0] lb;
        g_in_vld = v;
        g_in     = g;
        if (v) mbo = gray2bin(g);
        e.vld = v;
        e.b   = mbo;
`ifdef GRAY_CHK_EN
        e.err = v && marmed && ($countones(g ^ mref) > 1);
        if (v) begin
            mref   = g;
            marmed = 1'b1;
        end
`else
        e.err = 1'b0;
`endif
        sb.push_back(e);
        ld = load; ce = en; cu = up; lb = load_bin;
        @(posedge clk);
        if (ld)      mb = lb;
        else if (ce) mb = cu ? mb + 4'd1 : mb - 4'd1;
        #1;
        check_eq("B", B, mb);
        check_eq("G", G, mb ^ (mb >> 1));
        check_eq("tc", tc, up ? (mb == 4'd15) : (mb == 4'd0));
        if (sb.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check_eq("b_out_vld", b_out_vld, e.vld);
            check_eq("b_out", b_out, e.b);
            check_eq("chk_err", chk_err, e.err);
        end
    endtask

    task automatic reset_check(input string tag);
        check_eq({tag, "_B"}, B, 0);
        check_eq({tag, "_G"}, G, 0);
        check_eq({tag, "_vld"}, b_out_vld, 0);
        check_eq({tag, "_bout"}, b_out, 0);
        check_eq({tag, "_err"}, chk_err, 0);
        check_eq({tag, "_B5"}, B5, 5);
        check_eq({tag, "_G5"}, G5, 7);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rst5 = 1'b1;
        en = 1'b0; up = 1'b1; load = 1'b0; load_bin = 4'd0;
        g_in = 4'd0; g_in_vld = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_check("rst0");
        rst = 1'b0; rst5 = 1'b0;

        // Full up-count with wrap.
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1'b0, 4'd0);
            check_eq("seq_B", B, k % 16);
            check_eq("seq_G", G, gtab[k % 16]);
        end

        // Load overrides count, then count down.
        load = 1'b1; load_bin = 4'd9;
        tick(1'b0, 4'd0);
        check_eq("load_B", B, 9);
        check_eq("load_G", G, 13);
        load = 1'b0; up = 1'b0;
        tick(1'b0, 4'd0);
        check_eq("dn1_B", B, 8);  check_eq("dn1_G", G, 12);
        tick(1'b0, 4'd0);
        check_eq("dn2_B", B, 7);  check_eq("dn2_G", G, 4);

        // Down-wrap from 0.
        load = 1'b1; load_bin = 4'd0;
        tick(1'b0, 4'd0);
        load = 1'b0; up = 1'b0; en = 1'b1;
        #1;
        check_eq("tc_dn0", tc, 1);
        tick(1'b0, 4'd0);
        check_eq("wrap_B", B, 15);
        check_eq("wrap_G", G, 8);

        // Decode channel, including hold after the burst.
        en = 1'b0;
        tick(1'b1, 4'b1101);
        check_eq("dec0", b_out, 9);
        tick(1'b1, 4'b1111);
        check_eq("dec1", b_out, 10);
        tick(1'b1, 4'b0000);
        check_eq("dec2", b_out, 0);
        tick(1'b0, 4'b1010);
        tick(1'b0, 4'b0110);
        for (int k = 0; k < 8; k++) tick($urandom_range(0, 1), 4'($urandom_range(0, 15)));

        // Asynchronous reset mid-count with a pending valid.
        rst = 1'b1; rst5 = 1'b1;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0; rst5 = 1'b0;
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 5; k++) tick(1'b0, 4'd0);
        tick(1'b1, 4'b0011);
        check_eq("pre_rst_B", B, 6);
        #3;
        rst = 1'b1; rst5 = 1'b1;
        #1;
        reset_check("arst");
        model_reset();
        g_in_vld = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0; rst5 = 1'b0;
        en = 1'b0;

        // Checker sequence (expects a pulse only when the macro is defined).
        tick(1'b1, 4'b0000);
        tick(1'b1, 4'b0001);
        tick(1'b1, 4'b0001);
        tick(1'b1, 4'b0111);
`ifdef GRAY_CHK_EN
        check_eq("chk_pulse", chk_err, 1);
`else
        check_eq("chk_tied", chk_err, 0);
`endif
        tick(1'b0, 4'd0);
        check_eq("chk_clear", chk_err, 0);

        // Load and decode in the same cycle.
        load = 1'b1; load_bin = 4'd3;
        tick(1'b1, 4'b1000);
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick(1'b1, 4'b1001);
        tick(1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
